// File: rtl/mem_arbiter.sv
// mem_arbiter
// Lets the I-cache and the D-cache share one slow memory port. One cache-line
// transaction is in flight at a time. When both caches request in the same
// idle cycle, the side that was not granted last time wins, so the two caches
// alternate. The memory-side request is registered. mem_ready and mem_rdata
// are steered back only to the cache that owns the transaction. Saturating
// counters record grants per side and the idle cycles in which both sides
// were requesting.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata   I-cache line request
//   i_rdata/i_ready                 I-cache read data and completion
//   d_*                             same set of signals for the D-cache
//   mem_read/mem_write/mem_addr/
//   mem_wdata                       registered request to slow memory
//   mem_rdata/mem_ready             slow memory response
//   i_grant_cnt/d_grant_cnt         transactions granted per side
//   conflict_cnt                    idle cycles with both sides requesting
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_r;
    state_t              state_s;
    logic                last_grant_r;
    logic                i_req_s;
    logic                d_req_s;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                conflict_s;
    logic                done_s;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [LINE_W-1:0]   mem_wdata_r;
    logic [CNT_W-1:0]    i_grant_cnt_r;
    logic [CNT_W-1:0]    d_grant_cnt_r;
    logic [CNT_W-1:0]    conflict_cnt_r;
    logic                i_ready_s;
    logic                d_ready_s;
    logic [LINE_W-1:0]   i_rdata_s;
    logic [LINE_W-1:0]   d_rdata_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign i_req_s = i_read | i_write;
    assign d_req_s = d_read | d_write;

    // Next-state logic and the arbitration decision made in IDLE.
    always_comb begin
        state_s    = state_r;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        conflict_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                conflict_s = i_req_s & d_req_s;
                // I wins if it asks alone, or if both ask and D was served last.
                if (i_req_s && (!d_req_s || (last_grant_r == GRANT_D))) begin
                    grant_i_s = 1'b1;
                    state_s   = BUSY_I;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                    state_s   = BUSY_D;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                done_s = mem_ready;
                if (mem_ready) begin
                    state_s = RELEASE;
                end else begin
                    state_s = state_r;
                end
            end
            // The cache drops its request one cycle after ready, so this
            // cycle is spent ignoring requests and then returning to IDLE.
            RELEASE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, memory request registers, grant ownership and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            last_grant_r   <= GRANT_D;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {LINE_W{1'b0}};
            i_grant_cnt_r  <= {CNT_W{1'b0}};
            d_grant_cnt_r  <= {CNT_W{1'b0}};
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (grant_i_s) begin
                // A request with both read and write high is issued as a write.
                mem_read_r    <= i_read & ~i_write;
                mem_write_r   <= i_write;
                mem_addr_r    <= i_addr;
                mem_wdata_r   <= i_wdata;
                last_grant_r  <= GRANT_I;
                i_grant_cnt_r <= sat_inc(i_grant_cnt_r);
            end else if (grant_d_s) begin
                mem_read_r    <= d_read & ~d_write;
                mem_write_r   <= d_write;
                mem_addr_r    <= d_addr;
                mem_wdata_r   <= d_wdata;
                last_grant_r  <= GRANT_D;
                d_grant_cnt_r <= sat_inc(d_grant_cnt_r);
            end else if (done_s) begin
                // Address and data stay put; only the strobes drop.
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
            end else begin
                mem_read_r  <= mem_read_r;
                mem_write_r <= mem_write_r;
            end
            if (conflict_s) begin
                conflict_cnt_r <= sat_inc(conflict_cnt_r);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    // Steer the memory response to the owner only; IDLE and RELEASE forward nothing.
    always_comb begin
        i_ready_s = 1'b0;
        d_ready_s = 1'b0;
        i_rdata_s = {LINE_W{1'b0}};
        d_rdata_s = {LINE_W{1'b0}};
        if (state_r == BUSY_I) begin
            i_ready_s = mem_ready;
            i_rdata_s = mem_rdata;
        end else if (state_r == BUSY_D) begin
            d_ready_s = mem_ready;
            d_rdata_s = mem_rdata;
        end else begin
            i_ready_s = 1'b0;
            d_ready_s = 1'b0;
        end
    end

    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign i_grant_cnt  = i_grant_cnt_r;
    assign d_grant_cnt  = d_grant_cnt_r;
    assign conflict_cnt = conflict_cnt_r;
    assign i_ready      = i_ready_s;
    assign d_ready      = d_ready_s;
    assign i_rdata      = i_rdata_s;
    assign d_rdata      = d_rdata_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The counters are narrowed to 4 bits so that
// saturation is reachable. Expected values come from the arbitration rules:
// round-robin on conflict, the granted side's fields latched, and a
// saturating count of grants and conflicts.
module tb_mem_arbiter;
    localparam int ADDR_W  = 28;
    localparam int LINE_W  = 128;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic              i_ready, d_ready;
    logic              mem_read, mem_write, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic [CNT_W-1:0]  i_grant_cnt, d_grant_cnt, conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // One cycle: past the rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %0b exp 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got %0b exp 0", mem_write); end
        n_cmp++; if (mem_addr !== 28'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'h0) begin n_bad++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b exp 00", {i_ready, d_ready}); end
        n_cmp++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 12'h0) begin n_bad++; $display("FAIL reset_counters got %h exp 0", {i_grant_cnt, d_grant_cnt, conflict_cnt}); end
    endtask

    task automatic test_single_i_read();
        logic [LINE_W-1:0] pat;
        pat = {16{8'hA5}};
        do_reset();
        i_read = 1'b1; i_addr = 28'h0000010;
        step();
        n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_bad++; $display("FAIL single_op got r%0b w%0b exp r1 w0", mem_read, mem_write); end
        n_cmp++; if (mem_addr !== 28'h0000010) begin n_bad++; $display("FAIL single_addr got %h exp 0000010", mem_addr); end
        step();
        mem_ready = 1'b1; mem_rdata = pat;
        #1;
        n_cmp++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready got i%0b d%0b exp i1 d0", i_ready, d_ready); end
        n_cmp++; if (i_rdata !== pat) begin n_bad++; $display("FAIL single_rdata got %h exp %h", i_rdata, pat); end
        step();
        mem_ready = 1'b0;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL single_read_clear got %0b exp 0", mem_read); end
        step();
        i_read = 1'b0;
        n_cmp++; if (i_grant_cnt !== 4'd1) begin n_bad++; $display("FAIL single_grant_cnt got %0d exp 1", i_grant_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_read = 1'b1; i_addr = 28'h0000123;
        d_write = 1'b1; d_addr = 28'h0ABCDEF; d_wdata = {4{32'hDEADBEEF}};
        step();
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000123) begin n_bad++; $display("FAIL simul_first got r%0b addr %h exp r1 addr 0000123", mem_read, mem_addr); end
        step();
        mem_ready = 1'b1; mem_rdata = {4{32'h12345678}};
        #1;
        n_cmp++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready_i got i%0b d%0b exp i1 d0", i_ready, d_ready); end
        step();
        mem_ready = 1'b0;
        step();
        i_read = 1'b0;
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL simul_release_idle got w%0b exp 0", mem_write); end
        step();
        n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_bad++; $display("FAIL simul_second_op got r%0b w%0b exp r0 w1", mem_read, mem_write); end
        n_cmp++; if (mem_addr !== 28'h0ABCDEF || mem_wdata !== {4{32'hDEADBEEF}}) begin n_bad++; $display("FAIL simul_second_data got %h %h", mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready_d got i%0b d%0b exp i0 d1", i_ready, d_ready); end
        step();
        mem_ready = 1'b0;
        step();
        d_write = 1'b0;
        n_cmp++; if (conflict_cnt !== 4'd1 || i_grant_cnt !== 4'd1 || d_grant_cnt !== 4'd1) begin n_bad++; $display("FAIL simul_counts got c%0d i%0d d%0d exp 1 1 1", conflict_cnt, i_grant_cnt, d_grant_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_read = 1'b1; i_addr = 28'h1111111;
        d_read = 1'b1; d_addr = 28'h2222222;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (mem_addr !== ((k % 2 == 0) ? 28'h1111111 : 28'h2222222)) begin n_bad++; $display("FAIL b2b_order k=%0d got %h", k, mem_addr); end
            mem_ready = 1'b1;
            #1;
            n_cmp++; if ({i_ready, d_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL b2b_ready k=%0d got %b", k, {i_ready, d_ready}); end
            step();
            mem_ready = 1'b0;
            step();
        end
        i_read = 1'b0; d_read = 1'b0;
        n_cmp++; if (!(conflict_cnt inside {4'd5, 4'd6}) || i_grant_cnt !== 4'd3 || d_grant_cnt !== 4'd3) begin n_bad++; $display("FAIL b2b_counts got c%0d i%0d d%0d exp c5/6 i3 d3", conflict_cnt, i_grant_cnt, d_grant_cnt); end
    endtask

    task automatic test_release_hold();
        do_reset();
        d_read = 1'b1; d_addr = 28'h0000777;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        d_read = 1'b0;
        step();
        step();
        n_cmp++; if (mem_read !== 1'b0 || d_grant_cnt !== 4'd1) begin n_bad++; $display("FAIL release_no_regrant got r%0b cnt %0d exp r0 cnt 1", mem_read, d_grant_cnt); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_bad++; $display("FAIL stray_ready got %b exp 00", {i_ready, d_ready}); end
        step();
        mem_ready = 1'b0;
        n_cmp++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL stray_ready_idle got r%0b w%0b", mem_read, mem_write); end
    endtask

    task automatic test_reset_busy_d();
        do_reset();
        d_write = 1'b1; d_addr = 28'h0000ABC; d_wdata = {2{64'hCAFEF00DCAFEF00D}};
        step();
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rstbusy_grant got w%0b exp 1", mem_write); end
        rst = 1'b1;
        step();
        rst = 1'b0; d_write = 1'b0;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin n_bad++; $display("FAIL rstbusy_mem got %b %h %h exp zero", {mem_read, mem_write}, mem_addr, mem_wdata); end
        n_cmp++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 12'h0) begin n_bad++; $display("FAIL rstbusy_counters got %h exp 0", {i_grant_cnt, d_grant_cnt, conflict_cnt}); end
        mem_ready = 1'b1; mem_rdata = {4{32'h55AA55AA}};
        #1;
        n_cmp++; if (d_ready !== 1'b0 || d_rdata !== 128'h0) begin n_bad++; $display("FAIL rstbusy_late_ready got %0b %h exp 0", d_ready, d_rdata); end
        step();
        mem_ready = 1'b0;
        i_read = 1'b1; i_addr = 28'h0000001;
        d_read = 1'b1; d_addr = 28'h0000002;
        step();
        n_cmp++; if (mem_addr !== 28'h0000001) begin n_bad++; $display("FAIL rstbusy_last_grant got %h exp 0000001", mem_addr); end
        i_read = 1'b0; d_read = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            i_read = 1'b1; i_addr = ADDR_W'(k);
            step();
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            step();
            i_read = 1'b0;
        end
        n_cmp++; if (i_grant_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_i_grant got %h exp F", i_grant_cnt); end
        n_cmp++; if (d_grant_cnt !== 4'h0 || conflict_cnt !== 4'h0) begin n_bad++; $display("FAIL sat_others got d%h c%h exp 0 0", d_grant_cnt, conflict_cnt); end
    endtask

    task automatic test_random();
        bit                pend_i, pend_d, g_d, last_d;
        logic [1:0]        op_i, op_d, op_g;
        logic [ADDR_W-1:0] a_g;
        logic [LINE_W-1:0] w_g, rd;
        int                ni, nd, nc, lat;
        do_reset();
        pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b1;
        op_i = 2'b00; op_d = 2'b00;
        ni = 0; nd = 0; nc = 0;
        for (int k = 0; k < 40; k++) begin
            if (!pend_i && ($urandom_range(0, 1) == 1)) begin
                pend_i = 1'b1; op_i = 2'($urandom_range(1, 3));
                i_addr = ADDR_W'($urandom()); i_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (!pend_d && ($urandom_range(0, 1) == 1)) begin
                pend_d = 1'b1; op_d = 2'($urandom_range(1, 3));
                d_addr = ADDR_W'($urandom()); d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (!pend_i && !pend_d) begin
                pend_d = 1'b1; op_d = 2'($urandom_range(1, 3));
                d_addr = ADDR_W'($urandom()); d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            i_read = pend_i & op_i[0]; i_write = pend_i & op_i[1];
            d_read = pend_d & op_d[0]; d_write = pend_d & op_d[1];
            // Round-robin: alone wins; both -> whoever was not served last.
            if (pend_i && pend_d) begin
                g_d = ~last_d; nc++;
            end else begin
                g_d = pend_d;
            end
            last_d = g_d;
            if (g_d) begin nd++; op_g = op_d; a_g = d_addr; w_g = d_wdata; end
            else begin ni++; op_g = op_i; a_g = i_addr; w_g = i_wdata; end
            step();
            n_cmp++; if ({mem_read, mem_write} !== {op_g[0] & ~op_g[1], op_g[1]}) begin n_bad++; $display("FAIL rand_op k=%0d got %b exp %b", k, {mem_read, mem_write}, {op_g[0] & ~op_g[1], op_g[1]}); end
            n_cmp++; if (mem_addr !== a_g || mem_wdata !== w_g) begin n_bad++; $display("FAIL rand_fields k=%0d got %h exp %h", k, mem_addr, a_g); end
            // Requester sometimes gives up mid-transaction; completion must still reach it.
            if ($urandom_range(0, 3) == 0) begin
                if (g_d) begin d_read = 1'b0; d_write = 1'b0; end
                else begin i_read = 1'b0; i_write = 1'b0; end
            end
            lat = $urandom_range(0, 3);
            repeat (lat) step();
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_ready = 1'b1; mem_rdata = rd;
            #1;
            n_cmp++; if ({i_ready, d_ready} !== (g_d ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL rand_ready k=%0d got %b", k, {i_ready, d_ready}); end
            n_cmp++; if ((g_d ? d_rdata : i_rdata) !== rd || (g_d ? i_rdata : d_rdata) !== 128'h0) begin n_bad++; $display("FAIL rand_rdata k=%0d got %h exp %h", k, (g_d ? d_rdata : i_rdata), rd); end
            step();
            mem_ready = 1'b0;
            n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL rand_clear k=%0d got %b exp 00", k, {mem_read, mem_write}); end
            step();
            if (g_d) begin pend_d = 1'b0; d_read = 1'b0; d_write = 1'b0; end
            else begin pend_i = 1'b0; i_read = 1'b0; i_write = 1'b0; end
        end
        n_cmp++; if (i_grant_cnt !== CNT_W'(sat(ni)) || d_grant_cnt !== CNT_W'(sat(nd)) || conflict_cnt !== CNT_W'(sat(nc))) begin
            n_bad++; $display("FAIL rand_counts got i%0d d%0d c%0d exp i%0d d%0d c%0d", i_grant_cnt, d_grant_cnt, conflict_cnt, sat(ni), sat(nd), sat(nc));
        end
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_i_read();
        test_simultaneous();
        test_back_to_back();
        test_release_hold();
        test_reset_busy_d();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one slow memory port between the I-cache and the D-cache of CHIP. Today each cache drives its own slow memory; this block is what lets them share a single memory instance instead. It grants one cache line transaction at a time with round-robin fairness, registers the memory-side request, and routes `mem_ready`/`mem_rdata` back to the owner only. It also keeps saturating performance counters that the TestBed can sample.

## Interface
Parameters:
- `ADDR_W`, 28: line address width (byte address bits 31:4)
- `LINE_W`, 128: cache line width
- `CNT_W`, 16: performance counter width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_read`, `i_write`  in  1 each  I-cache line read/write request
- `i_addr`  in  ADDR_W  I-cache line address
- `i_wdata`  in  LINE_W  I-cache write line
- `i_rdata`  out  LINE_W  read line to I-cache
- `i_ready`  out  1  I-cache transaction complete
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: same as the I-cache ports, for the D-cache
- `mem_read`, `mem_write`  out  1 each  request to slow memory
- `mem_addr`  out  ADDR_W  line address to memory
- `mem_wdata`  out  LINE_W  write line to memory
- `mem_rdata`  in  LINE_W  read line from memory
- `mem_ready`  in  1  memory completion pulse
- `i_grant_cnt`, `d_grant_cnt`  out  CNT_W  transactions granted per side
- `conflict_cnt`  out  CNT_W  arbitration cycles in which both sides were requesting

## Operation
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- A side is requesting when `x_read | x_write` is high.
- **IDLE**
  - If only one side is requesting, grant it.
  - If both are requesting, grant the side that is not `last_grant` and increment `conflict_cnt`.
  - On grant:
    - latch addr, wdata and op into the `mem_*` registers;
    - a request with both read and write high is treated as a write;
    - set `last_grant` to the granted side;
    - increment that side's grant counter;
    - go to BUSY_x.
- **BUSY_x**
  - Hold `mem_*` outputs constant.
  - Route `mem_ready` to `x_ready` and `mem_rdata` to `x_rdata` combinationally.
  - The other side's ready is 0 and its rdata is 0.
  - When `mem_ready` is high: clear `mem_read`/`mem_write` at the next edge and go to RELEASE.
  - If the requester drops its request mid-transaction, the transaction still completes and the ready pulse is still forwarded.
- **RELEASE**
  - Lasts one cycle. Requests are ignored, because the cache deasserts its request registered, one cycle after ready.
  - Go to IDLE.
- `last_grant` resets to D, so the first conflict grants I.
- Counters saturate at all-ones and never wrap.
- Reset:
  - When `rst` is high at an edge: state goes to IDLE, all `mem_*` outputs to 0, counters to 0, `last_grant` to D.
  - This applies mid-transaction too: the in-flight request is abandoned and no ready is forwarded after reset.
  - Stray `mem_ready` in IDLE or RELEASE is ignored and not forwarded.

## Timing
- Reset values: all outputs 0.
- Grant latency: a request sampled in IDLE at edge t gives `mem_read`/`mem_write` high after edge t (one registered cycle).
- Completion: `mem_ready` high in cycle r gives `x_ready` high in the same cycle r. `mem_read`/`mem_write` are low after edge r. State is IDLE after edge r+1.
- Back-to-back: a pending other-side request is granted at edge r+2, so the earliest next `mem_*` assertion is 2 cycles after ready.
- Arbitration overhead per transaction: 2 cycles (grant edge plus RELEASE) on top of the memory latency.
- `mem_addr` and `mem_wdata` change only on grant edges and on reset.

## Test plan
- **Single I read:** `i_read=1`, `i_addr=28'h0000010`; memory returns `128'hA5..A5` on ready.
  - `mem_read=1` one cycle after the request, with `mem_addr=28'h0000010`.
  - `i_rdata=A5..A5` and `i_ready=1` in the ready cycle; `d_ready=0`.
  - `i_grant_cnt=1`.
- **Simultaneous I read and D write right after reset:**
  - I is served first (`last_grant=D`). D's write is issued with its `d_wdata` 2 cycles after I's ready.
  - `conflict_cnt=1`, each grant counter is 1.
- **Both sides requesting continuously for 6 transactions:** grants alternate I, D, I, D, I, D; `conflict_cnt` is 5 or 6.
- **D-cache holds `d_read` one cycle after ready:** no second D grant occurs (the RELEASE state absorbs it); the arbiter is IDLE afterwards.
- **`rst=1` pulsed while BUSY_D:**
  - All outputs are 0 the next cycle and counters are 0.
  - A later `mem_ready` produces no `d_ready`.
- **Saturation:** with `CNT_W=4`, 20 I reads leave `i_grant_cnt=4'hF`.
